// File: rtl/hoeraa_pipe_pkg.sv
// rtl/hoeraa_pipe_pkg.sv - shared helpers for the pipelined runtime-configurable approximate adder
package hoeraa_pipe_pkg;

  localparam int WIDE_W = 64;
  typedef logic [WIDE_W-1:0] wide_t;

  // k of 0 or 1 means exact addition; anything above p_max is pulled down to p_max
  function automatic logic [7:0] clamp_k(input logic [7:0] k, input logic [7:0] p_max);
    if (k < 8'd2) return 8'd0;
    else if (k > p_max) return p_max;
    else return k;
  endfunction

  function automatic wide_t abs_diff(input wide_t a, input wide_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Result is clamped to the all-ones value of a w-bit field
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    logic [WIDE_W:0] s;
    logic [WIDE_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((WIDE_W+1)'(1) << w) - (WIDE_W+1)'(1);
    return (s > lim) ? lim[WIDE_W-1:0] : s[WIDE_W-1:0];
  endfunction

endpackage

// File: rtl/hoeraa_var.sv
// rtl/hoeraa_var.sv - combinational error-reduced approximate adder with runtime approximate-part length
module hoeraa_var
  import hoeraa_pipe_pkg::*;
#(
  parameter int N   = 16,
  parameter int K_W = 4
) (
  input  logic [N-1:0]   i_x,
  input  logic [N-1:0]   i_y,
  input  logic [K_W-1:0] i_keff,
  output logic [N:0]     o_sum
);

  logic [N:0]     w_xw;
  logic [N:0]     w_yw;
  logic [N:0]     w_hi;
  logic [N:0]     w_ones;
  logic [N:0]     w_pair;
  logic [1:0]     w_xs;
  logic [1:0]     w_ys;
  logic [K_W-1:0] w_sh;
  logic           w_c;
  logic           w_s_hi;
  logic           w_s_lo;

  always_comb begin
    w_xw   = {1'b0, i_x};
    w_yw   = {1'b0, i_y};
    w_sh   = i_keff - K_W'(2);
    // w_xs/w_ys hold bits m-1 and m-2 of each operand
    w_xs   = 2'(w_xw >> w_sh);
    w_ys   = 2'(w_yw >> w_sh);
    w_c    = w_xs[1] & w_ys[1];
    w_s_hi = w_c ? (w_xs[0] & w_ys[0]) : (w_xs[1] | w_ys[1]);
    w_s_lo = w_xs[0] | w_ys[0];
    w_ones = ((N+1)'(1) << w_sh) - (N+1)'(1);
    w_pair = {{(N-1){1'b0}}, w_s_hi, w_s_lo} << w_sh;
    w_hi   = ((w_xw >> i_keff) + (w_yw >> i_keff) + (N+1)'(w_c)) << i_keff;
    o_sum  = w_hi | w_pair | w_ones;
    if (i_keff < K_W'(2)) o_sum = w_xw + w_yw;
  end

endmodule

// File: rtl/hoeraa_pipe.sv
// rtl/hoeraa_pipe.sv - two-stage valid/ready approximate adder with in-system error statistics
module hoeraa_pipe
  import hoeraa_pipe_pkg::*;
#(
  parameter int N     = 16,
  parameter int P_MAX = 8,
  parameter int ACC_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  input  logic [$clog2(P_MAX+1)-1:0] k,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N:0]                 sum,
  output logic [N:0]                 exact,
  output logic [N:0]                 err,
  input  logic                       stats_clr,
  output logic [ACC_W-1:0]           err_acc,
  output logic [N:0]                 err_max,
  output logic [ACC_W-1:0]           txn_cnt
);

  localparam int K_W = $clog2(P_MAX+1);

  logic             r_s1_valid;
  logic [N-1:0]     r_x;
  logic [N-1:0]     r_y;
  logic [K_W-1:0]   r_keff;
  logic             r_s2_valid;
  logic [N:0]       r_sum;
  logic [N:0]       r_exact;
  logic [N:0]       r_err;
  logic [ACC_W-1:0] r_err_acc;
  logic [N:0]       r_err_max;
  logic [ACC_W-1:0] r_txn_cnt;

  logic             w_s2_adv;
  logic             w_xfer;
  logic [7:0]       w_keff_wide;
  logic [N:0]       w_sum_a;
  logic [N:0]       w_exact;
  wide_t            w_err_wide;
  wide_t            w_acc_wide;
  wide_t            w_cnt_wide;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W-1:0] w_cnt_base;
  logic [N:0]       w_max_base;
  logic             w_unused;

  assign w_s2_adv    = !r_s2_valid | out_ready;
  assign in_ready    = !r_s1_valid | w_s2_adv;
  assign w_xfer      = r_s2_valid & out_ready;
  assign w_keff_wide = clamp_k(8'(k), 8'(P_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_keff     <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_x    <= x;
        r_y    <= y;
        r_keff <= w_keff_wide[K_W-1:0];
      end
    end
  end

  hoeraa_var #(.N(N), .K_W(K_W)) u_var (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_keff (r_keff),
    .o_sum  (w_sum_a)
  );

  assign w_exact    = {1'b0, r_x} + {1'b0, r_y};
  assign w_err_wide = abs_diff(wide_t'(w_exact), wide_t'(w_sum_a));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_exact    <= '0;
      r_err      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum   <= w_sum_a;
        r_exact <= w_exact;
        r_err   <= w_err_wide[N:0];
      end
    end
  end

  // A clear coinciding with a transfer accumulates onto zeroed statistics
  assign w_acc_base = stats_clr ? '0 : r_err_acc;
  assign w_cnt_base = stats_clr ? '0 : r_txn_cnt;
  assign w_max_base = stats_clr ? '0 : r_err_max;
  assign w_acc_wide = sat_add(wide_t'(w_acc_base), wide_t'(r_err), ACC_W);
  assign w_cnt_wide = sat_add(wide_t'(w_cnt_base), wide_t'(1), ACC_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_acc <= '0;
      r_err_max <= '0;
      r_txn_cnt <= '0;
    end else if (w_xfer) begin
      r_err_acc <= w_acc_wide[ACC_W-1:0];
      r_err_max <= (r_err > w_max_base) ? r_err : w_max_base;
      r_txn_cnt <= w_cnt_wide[ACC_W-1:0];
    end else if (stats_clr) begin
      r_err_acc <= '0;
      r_err_max <= '0;
      r_txn_cnt <= '0;
    end
  end

  assign w_unused = ^{w_keff_wide[7:K_W], w_err_wide[WIDE_W-1:N+1],
                      w_acc_wide[WIDE_W-1:ACC_W], w_cnt_wide[WIDE_W-1:ACC_W]};

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign exact     = r_exact;
  assign err       = r_err;
  assign err_acc   = r_err_acc;
  assign err_max   = r_err_max;
  assign txn_cnt   = r_txn_cnt;

endmodule

// File: tb/tb_hoeraa_pipe.sv
// tb/tb_hoeraa_pipe.sv - self-checking bench for hoeraa_pipe against an arithmetic reference model
module tb_hoeraa_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [3:0]  k;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] sum;
  logic [16:0] exact;
  logic [16:0] err;
  logic        stats_clr;
  logic [31:0] err_acc;
  logic [16:0] err_max;
  logic [31:0] txn_cnt;

  always #5 clk = ~clk;

  hoeraa_pipe #(.N(16), .P_MAX(8), .ACC_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .exact     (exact),
    .err       (err),
    .stats_clr (stats_clr),
    .err_acc   (err_acc),
    .err_max   (err_max),
    .txn_cnt   (txn_cnt)
  );

  typedef struct {
    longint s;
    longint e;
    longint r;
    int     cyc;
  } exp_t;

  exp_t   q[$];
  int     tests = 0;
  int     fails = 0;
  int     cyc   = 0;
  int     n_acc = 0;
  longint m_acc = 0;
  longint m_max = 0;
  longint m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic longint model_sum(input longint xv, input longint yv, input int kv);
    int     m;
    longint c, hb, lb;
    if (kv < 2) m = 0;
    else if (kv > 8) m = 8;
    else m = kv;
    if (m == 0) return xv + yv;
    c  = (xv >> (m-1)) & (yv >> (m-1)) & 1;
    lb = ((xv >> (m-2)) | (yv >> (m-2))) & 1;
    hb = (c == 1) ? ((xv >> (m-2)) & (yv >> (m-2)) & 1) : (((xv >> (m-1)) | (yv >> (m-1))) & 1);
    return ((((xv >> m) + (yv >> m) + c) << m) + (hb << (m-1)) + (lb << (m-2)) + ((longint'(1) << (m-2)) - 1));
  endfunction

  task automatic tick();
    exp_t   it;
    bit     acc;
    bit     xfer;
    longint xv, yv;
    #1;
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2 || out_ready));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0 && (cyc - q[0].cyc) >= 2));
      if (out_valid && q.size() > 0) begin
        chk("sum", 64'(sum), q[0].s);
        chk("exact", 64'(exact), q[0].e);
        chk("err", 64'(err), q[0].r);
      end
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (stats_clr) begin
        m_acc = 0; m_max = 0; m_cnt = 0;
      end
      if (xfer && q.size() > 0) begin
        it    = q.pop_front();
        m_acc = m_acc + it.r;
        if (m_acc > 64'hFFFF_FFFF) m_acc = 64'hFFFF_FFFF;
        if (it.r > m_max) m_max = it.r;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
      if (acc) begin
        xv     = longint'(x);
        yv     = longint'(y);
        it.s   = model_sum(xv, yv, int'(k));
        it.e   = xv + yv;
        it.r   = (it.s > it.e) ? it.s - it.e : it.e - it.s;
        it.cyc = cyc;
        q.push_back(it);
        n_acc++;
      end
    end else begin
      q.delete();
      m_acc = 0; m_max = 0; m_cnt = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("err_acc", 64'(err_acc), m_acc);
    chk("err_max", 64'(err_max), m_max);
    chk("txn_cnt", 64'(txn_cnt), m_cnt);
  endtask

  task automatic drive(input logic v, input logic [15:0] xv, input logic [15:0] yv, input logic [3:0] kv);
    in_valid = v;
    x = xv;
    y = yv;
    k = kv;
  endtask

  task automatic drain();
    int b;
    b = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && b < 50) begin
      tick();
      b++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base;
    int b;
    rst_n = 1'b0;
    stats_clr = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_exact", 64'(exact), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // first transaction: latency and values
    drive(1'b1, 16'h00FF, 16'h0001, 4'd8);
    tick();
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    chk("lat_1cyc_not_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_2cyc_valid", 64'(out_valid), 64'd1);
    chk("t1_sum", 64'(sum), 64'h000FF);
    chk("t1_exact", 64'(exact), 64'h00100);
    chk("t1_err", 64'(err), 64'd1);
    tick();
    chk("t1_txn_cnt", 64'(txn_cnt), 64'd1);

    drive(1'b1, 16'h0080, 16'h0080, 4'd8);
    tick();
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    tick();
    chk("t2_sum", 64'(sum), 64'h0013F);
    chk("t2_exact", 64'(exact), 64'h00100);
    chk("t2_err", 64'(err), 64'd63);
    tick();
    chk("t2_err_max", 64'(err_max), 64'd63);
    chk("t2_err_acc", 64'(err_acc), 64'd64);

    // exact modes and clamping, back to back
    drive(1'b1, 16'hFFFF, 16'h0001, 4'd0);
    tick();
    drive(1'b1, 16'hFFFF, 16'h0001, 4'd1);
    tick();
    chk("k0_sum", 64'(sum), 64'h10000);
    chk("k0_err", 64'(err), 64'd0);
    drive(1'b1, 16'h0080, 16'h0080, 4'd15);
    tick();
    chk("k1_sum", 64'(sum), 64'h10000);
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    tick();
    chk("k15_clamped_sum", 64'(sum), 64'h0013F);
    drain();

    // backpressure: out_ready low for 5 cycles with 4 pending inputs
    base = n_acc;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (n_acc - base < 4) drive(1'b1, 16'($urandom), 16'($urandom), 4'($urandom));
      tick();
    end
    chk("bp_accepted", 64'(n_acc - base), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    b = 0;
    while (n_acc - base < 4 && b < 20) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 4'($urandom));
      tick();
      b++;
    end
    chk("bp_all_accepted", 64'(n_acc - base), 64'd4);
    drain();

    // clear coinciding with a transfer of err=5
    drive(1'b1, 16'h0006, 16'h0006, 4'd4);
    tick();
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("clr_err_acc", 64'(err_acc), 64'd5);
    chk("clr_err_max", 64'(err_max), 64'd5);
    chk("clr_txn_cnt", 64'(txn_cnt), 64'd1);

    // randomized traffic with toggling backpressure and occasional clears
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 4'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      stats_clr = 1'($urandom_range(0, 39) == 0);
      tick();
    end
    stats_clr = 1'b0;
    drain();

    // reset with two transactions in flight
    drive(1'b1, 16'h1234, 16'h4321, 4'd5);
    tick();
    drive(1'b1, 16'hABCD, 16'h0F0F, 4'd7);
    tick();
    drive(1'b0, 16'h0, 16'h0, 4'd0);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_err_acc", 64'(err_acc), 64'd0);
    chk("midrst_err_max", 64'(err_max), 64'd0);
    chk("midrst_txn_cnt", 64'(txn_cnt), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("midrst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
